// File: rtl/pipearch_ctrl_pkg.sv
// pipearch_ctrl_pkg: address map, CTRL bit positions and shared types for the
// PipeArch kernel control slave.
package pipearch_ctrl_pkg;

    localparam logic [31:0] ADDR_CTRL     = 32'h00;
    localparam logic [31:0] ADDR_GIE      = 32'h04;
    localparam logic [31:0] ADDR_IER      = 32'h08;
    localparam logic [31:0] ADDR_ISR      = 32'h0C;
    localparam logic [31:0] ADDR_RUNS     = 32'h10;
    localparam logic [31:0] ADDR_CFG_BASE = 32'h20;

    localparam int CTRL_AP_START     = 0;
    localparam int CTRL_AP_DONE      = 1;
    localparam int CTRL_AP_IDLE      = 2;
    localparam int CTRL_AP_READY     = 3;
    localparam int CTRL_AUTO_RESTART = 7;

    // Wide enough to index up to 32 config registers.
    localparam int CFG_IDX_W = 5;

    typedef logic [63:0] cfg_reg_t;

endpackage

// File: rtl/pipearch_axil_slave_if.sv
// pipearch_axil_slave_if: AXI4-Lite handshake front end. AW and W are each held
// in a one-deep register; the register-file write strobe fires in the cycle both
// are available (held or handshaking now). Reads return data one cycle after AR.
module pipearch_axil_slave_if #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data
);

    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              aw_hs;
    logic              w_hs;

    // Readies are forced low during reset so every output reads 0 then.
    assign awready = !reset && !aw_held && !bvalid;
    assign wready  = !reset && !w_held && !bvalid;
    assign arready = !reset && !rvalid;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // A beat arriving this cycle bypasses its holding register.
    assign wr_en   = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_addr = aw_held ? aw_addr_q : awaddr;
    assign wr_data = w_held ? w_data_q : wdata;
    assign wr_strb = w_held ? w_strb_q : wstrb;

    assign rd_en   = arvalid && arready;
    assign rd_addr = araddr;

    // Write channel control: hold flags and the B response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
        end else if (wr_en) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
        end else begin
            if (aw_hs)
                aw_held <= 1'b1;
            if (w_hs)
                w_held <= 1'b1;
            if (bvalid && bready)
                bvalid <= 1'b0;
        end
    end

    // Holding registers for a beat that arrives before its partner.
    always_ff @(posedge clk) begin
        if (aw_hs)
            aw_addr_q <= awaddr;
        if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    // Read channel: capture register-file data on the AR handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= 32'h0;
        end else if (rd_en) begin
            rvalid <= 1'b1;
            rdata  <= rd_data;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipearch_ctrl_regfile.sv
// pipearch_ctrl_regfile: AXI4-Lite control register file and start/done
// sequencer for PipeArch kernels. NUM_REGS 64-bit config registers, busy
// write-lock, auto-restart and a completed-run counter.
// Optional interrupt block (GIE/IER/ISR, interrupt pin) is built when the
// macro PIPEARCH_CTRL_IRQ_EN is defined; otherwise those offsets read 0.
module pipearch_ctrl_regfile
    import pipearch_ctrl_pkg::*;
#(
    parameter int NUM_REGS                   = 8,
    parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 8,
    parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    s_axi_control_AWVALID,
    output logic                                    s_axi_control_AWREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
    input  logic                                    s_axi_control_WVALID,
    output logic                                    s_axi_control_WREADY,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_WDATA,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
    output logic                                    s_axi_control_BVALID,
    input  logic                                    s_axi_control_BREADY,
    output logic [1:0]                              s_axi_control_BRESP,
    input  logic                                    s_axi_control_ARVALID,
    output logic                                    s_axi_control_ARREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_ARADDR,
    output logic                                    s_axi_control_RVALID,
    input  logic                                    s_axi_control_RREADY,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_RDATA,
    output logic [1:0]                              s_axi_control_RRESP,
    output logic [64*NUM_REGS-1:0]                  config_data,
    output logic [NUM_REGS-1:0]                     config_en,
    input  logic                                    ctrl_idle,
    input  logic                                    ctrl_done,
    output logic                                    interrupt
);

    localparam int          AW      = C_S_AXI_CONTROL_ADDR_WIDTH;
    localparam logic [31:0] CFG_END = ADDR_CFG_BASE + 32'(8 * NUM_REGS);

    logic          wr_en, rd_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [31:0]   wr_data, rd_data;
    logic [3:0]    wr_strb;

    cfg_reg_t      cfg_q [NUM_REGS];
    logic          ap_start, ap_done, auto_restart;
    logic [31:0]   run_count;
    logic          launch_p0;

    logic [31:0]          wa_al, ra_al;
    logic                 wr_ctrl, wr_cfg, wr_hi, rd_ctrl, rd_cfg, rd_hi, start_set;
    logic [CFG_IDX_W-1:0] wr_idx, rd_idx;

    pipearch_axil_slave_if #(.ADDR_W(AW)) u_axil (
        .clk     (clk),
        .reset   (reset),
        .awvalid (s_axi_control_AWVALID),
        .awready (s_axi_control_AWREADY),
        .awaddr  (s_axi_control_AWADDR),
        .wvalid  (s_axi_control_WVALID),
        .wready  (s_axi_control_WREADY),
        .wdata   (s_axi_control_WDATA),
        .wstrb   (s_axi_control_WSTRB),
        .bvalid  (s_axi_control_BVALID),
        .bready  (s_axi_control_BREADY),
        .bresp   (s_axi_control_BRESP),
        .arvalid (s_axi_control_ARVALID),
        .arready (s_axi_control_ARREADY),
        .araddr  (s_axi_control_ARADDR),
        .rvalid  (s_axi_control_RVALID),
        .rready  (s_axi_control_RREADY),
        .rdata   (s_axi_control_RDATA),
        .rresp   (s_axi_control_RRESP),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    // Word-aligned address decode for both channels.
    assign wa_al     = 32'(wr_addr) & 32'hFFFF_FFFC;
    assign ra_al     = 32'(rd_addr) & 32'hFFFF_FFFC;
    assign wr_ctrl   = wr_en && (wa_al == ADDR_CTRL);
    assign wr_cfg    = wr_en && (wa_al >= ADDR_CFG_BASE) && (wa_al < CFG_END);
    assign wr_idx    = CFG_IDX_W'((wa_al - ADDR_CFG_BASE) >> 3);
    assign wr_hi     = wa_al[2];
    assign rd_ctrl   = rd_en && (ra_al == ADDR_CTRL);
    assign rd_cfg    = (ra_al >= ADDR_CFG_BASE) && (ra_al < CFG_END);
    assign rd_idx    = CFG_IDX_W'((ra_al - ADDR_CFG_BASE) >> 3);
    assign rd_hi     = ra_al[2];
    // Start is W1S and only honoured while idle; a concurrent done sees ap_start=1.
    assign start_set = wr_ctrl && wr_strb[0] && wr_data[CTRL_AP_START] && !ap_start;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
        assign config_data[64*g +: 64] = cfg_q[g];
    end

    // Config registers: byte-strobed writes, locked while a run is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                cfg_q[i] <= '0;
        end else if (wr_cfg && !ap_start) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == CFG_IDX_W'(i)) begin
                    if (wr_hi)
                        cfg_q[i][63:32] <= merge_bytes(cfg_q[i][63:32], wr_data, wr_strb);
                    else
                        cfg_q[i][31:0] <= merge_bytes(cfg_q[i][31:0], wr_data, wr_strb);
                end
            end
        end
    end

    // Run sequencer: start/done/auto-restart, run counter and config-load pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ap_start     <= 1'b0;
            ap_done      <= 1'b0;
            auto_restart <= 1'b0;
            run_count    <= 32'h0;
            launch_p0    <= 1'b0;
            config_en    <= '0;
        end else begin
            if (start_set)
                ap_start <= 1'b1;
            else if (ctrl_done && !auto_restart)
                ap_start <= 1'b0;
            if (wr_ctrl && wr_strb[0])
                auto_restart <= wr_data[CTRL_AUTO_RESTART];
            if (ctrl_done)
                ap_done <= 1'b1;
            else if (rd_ctrl)
                ap_done <= 1'b0;
            if (ctrl_done)
                run_count <= run_count + 32'd1;
            // p0: ap_start has just risen; the load pulse follows one cycle later.
            launch_p0 <= start_set;
            config_en <= {NUM_REGS{launch_p0 || (ctrl_done && auto_restart && ap_start)}};
        end
    end

`ifdef PIPEARCH_CTRL_IRQ_EN
    logic gie_q, ier_q, isr_q, isr_d, irq_q;
    logic wr_gie, wr_ier, wr_isr;

    assign wr_gie = wr_en && (wa_al == ADDR_GIE) && wr_strb[0];
    assign wr_ier = wr_en && (wa_al == ADDR_IER) && wr_strb[0];
    assign wr_isr = wr_en && (wa_al == ADDR_ISR) && wr_strb[0];

    // ISR next state: a done event wins over a toggle in the same cycle.
    always_comb begin
        isr_d = isr_q;
        if (ctrl_done && ier_q)
            isr_d = 1'b1;
        else if (wr_isr && wr_data[0])
            isr_d = !isr_q;
    end

    // Interrupt enables, status and the registered interrupt line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gie_q <= 1'b0;
            ier_q <= 1'b0;
            isr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_gie)
                gie_q <= wr_data[0];
            if (wr_ier)
                ier_q <= wr_data[0];
            isr_q <= isr_d;
            irq_q <= gie_q && isr_d;
        end
    end

    assign interrupt = irq_q;
`else
    assign interrupt = 1'b0;
`endif

    // Read data mux; unmapped offsets return 0.
    always_comb begin
        rd_data = 32'h0;
        if (ra_al == ADDR_CTRL) begin
            rd_data[CTRL_AP_START]     = ap_start;
            rd_data[CTRL_AP_DONE]      = ap_done;
            rd_data[CTRL_AP_IDLE]      = ctrl_idle;
            rd_data[CTRL_AP_READY]     = ap_done;
            rd_data[CTRL_AUTO_RESTART] = auto_restart;
        end
        if (ra_al == ADDR_RUNS)
            rd_data = run_count;
`ifdef PIPEARCH_CTRL_IRQ_EN
        if (ra_al == ADDR_GIE)
            rd_data = {31'h0, gie_q};
        if (ra_al == ADDR_IER)
            rd_data = {31'h0, ier_q};
        if (ra_al == ADDR_ISR)
            rd_data = {31'h0, isr_q};
`else
        if (ra_al == ADDR_GIE || ra_al == ADDR_IER || ra_al == ADDR_ISR)
            rd_data = 32'h0;
`endif
        if (rd_cfg) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_idx == CFG_IDX_W'(i))
                    rd_data = rd_hi ? cfg_q[i][63:32] : cfg_q[i][31:0];
            end
        end
    end

endmodule

// File: tb/tb_pipearch_ctrl_regfile.sv
// tb_pipearch_ctrl_regfile: self-checking bench for the PipeArch control slave.
module tb_pipearch_ctrl_regfile;

    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [7:0]        awaddr, araddr;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic [64*NR-1:0]  config_data;
    logic [NR-1:0]     config_en;
    logic              ctrl_idle, ctrl_done, interrupt;

    int vectors = 0;
    int miscompares = 0;
    int en_pulses = 0;
    int runs = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [63:0] cfg_m [NR];

    pipearch_ctrl_regfile #(.NUM_REGS(NR), .C_S_AXI_CONTROL_ADDR_WIDTH(8),
                            .C_S_AXI_CONTROL_DATA_WIDTH(32)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .s_axi_control_AWVALID (awvalid),
        .s_axi_control_AWREADY (awready),
        .s_axi_control_AWADDR  (awaddr),
        .s_axi_control_WVALID  (wvalid),
        .s_axi_control_WREADY  (wready),
        .s_axi_control_WDATA   (wdata),
        .s_axi_control_WSTRB   (wstrb),
        .s_axi_control_BVALID  (bvalid),
        .s_axi_control_BREADY  (bready),
        .s_axi_control_BRESP   (bresp),
        .s_axi_control_ARVALID (arvalid),
        .s_axi_control_ARREADY (arready),
        .s_axi_control_ARADDR  (araddr),
        .s_axi_control_RVALID  (rvalid),
        .s_axi_control_RREADY  (rready),
        .s_axi_control_RDATA   (rdata),
        .s_axi_control_RRESP   (rresp),
        .config_data           (config_data),
        .config_en             (config_en),
        .ctrl_idle             (ctrl_idle),
        .ctrl_done             (ctrl_done),
        .interrupt             (interrupt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (config_en != '0)
            en_pulses <= en_pulses + 1;

`ifndef PIPEARCH_CTRL_IRQ_EN
    logic irq_seen = 1'b0;
    always @(negedge clk)
        if (interrupt)
            irq_seen <= 1'b1;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        runs++;
    endtask

    // Presents AW and W together; returns just after the edge that accepts both.
    task automatic aw_w(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic a_done, w_done, a_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        a_done = 1'b0; w_done = 1'b0;
        for (int c = 0; c < 20 && !(a_done && w_done); c++) begin
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            tick();
            if (a_hs) begin awvalid = 1'b0; a_done = 1'b1; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1'b1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(a_done && w_done)) begin
            vectors++; miscompares++;
            $display("FAIL wr_handshake: timeout at addr %h", a);
        end
    endtask

    task automatic b_wait();
        logic got;
        got = 1'b0;
        bready = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            got = bvalid;
            if (got && bresp != 2'b00) begin
                vectors++; miscompares++;
                $display("FAIL bresp: got %h expected 0", bresp);
            end
            tick();
        end
        bready = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL bvalid_wait: timeout");
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        aw_w(a, d, s);
        b_wait();
    endtask

    task automatic axi_read(input logic [7:0] a, input logic with_done, output logic [31:0] d);
        logic hs, got;
        araddr = a; arvalid = 1'b1; hs = 1'b0; got = 1'b0; d = 32'hDEAD_DEAD;
        if (with_done) begin ctrl_done = 1'b1; runs++; end
        for (int c = 0; c < 20 && !hs; c++) begin
            hs = arready;
            tick();
            ctrl_done = 1'b0;
        end
        arvalid = 1'b0;
        rready = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            got = rvalid;
            if (got) d = rdata;
            if (got && rresp != 2'b00) begin
                vectors++; miscompares++;
                $display("FAIL rresp: got %h expected 0", rresp);
            end
            tick();
        end
        rready = 1'b0;
        if (!(hs && got)) begin
            vectors++; miscompares++;
            $display("FAIL rd_handshake: timeout at addr %h", a);
        end
    endtask

    // Reference model: config space as an array of 64-bit words, bytes merged by lane.
    function automatic logic [31:0] model_rd(input logic [7:0] a);
        int off;
        off = int'(a) - 32'h20;
        if (off < 0 || off >= 8 * NR) return 32'h0;
        return (off % 8 >= 4) ? cfg_m[off / 8][63:32] : cfg_m[off / 8][31:0];
    endfunction

    task automatic model_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int off, base;
        off = int'(a) - 32'h20;
        if (off >= 0 && off < 8 * NR) begin
            base = (off % 8 >= 4) ? 32 : 0;
            for (int b = 0; b < 4; b++)
                if (s[b]) cfg_m[off / 8][base + 8*b +: 8] = d[8*b +: 8];
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        held_ok;
        int          base_p, k;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        reset = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        ctrl_idle = 1'b1; ctrl_done = 1'b0;

        vecs[0] = '{8'h20, 32'hAABBCCDD, 4'h5, 32'h00BB00DD};
        vecs[1] = '{8'h24, 32'h11223344, 4'hF, 32'h11223344};
        vecs[2] = '{8'h28, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
        vecs[3] = '{8'h28, 32'h12345678, 4'h2, 32'hFFFF56FF};
        vecs[4] = '{8'h2C, 32'hCAFEF00D, 4'h8, 32'hCA000000};
        vecs[5] = '{8'h5C, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vecs[6] = '{8'h60, 32'h00000055, 4'hF, 32'h00000000};
        vecs[7] = '{8'h14, 32'h12345678, 4'hF, 32'h00000000};
`ifdef PIPEARCH_CTRL_IRQ_EN
        vecs[8] = '{8'h08, 32'h00000001, 4'hF, 32'h00000001};
`else
        vecs[8] = '{8'h08, 32'h00000001, 4'hF, 32'h00000000};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_awready", awready, 0);
        check("rst_cfg_en", config_en, 0);
        check("rst_irq", interrupt, 0);
        check("rst_cfg_zero", config_data == '0, 1);
        @(negedge clk) reset = 1'b0;
        tick();
        axi_read(8'h00, 1'b0, r);
        check("ctrl_idle_read", r, 32'h04);
        ctrl_idle = 1'b0;

        // Table-driven register writes and readbacks
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_read(vecs[i].addr, 1'b0, r);
            check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), r, vecs[i].exp);
        end
        check("cfg0_strobed", config_data[63:0], 64'h1122334400BB00DD);

        // AW at cycle 0, W at cycle 3, BREADY held low
        awaddr = 8'h30; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("awready_held", awready, 0);
        tick(); tick();
        check("bvalid_before_w", bvalid, 0);
        check("cfg2_before_w", config_data[2*64 +: 32], 32'h0);
        wdata = 32'h600DF00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("cfg2_after_w", config_data[2*64 +: 32], 32'h600DF00D);
        check("bvalid_after_w", bvalid, 1);
        held_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!bvalid) held_ok = 1'b0;
        end
        check("bvalid_held", held_ok, 1);
        b_wait();
        check("bvalid_cleared", bvalid, 0);

        // Start, busy lock, done
        base_p = en_pulses;
        aw_w(8'h00, 32'h1, 4'hF);
        check("cfg_en_same_cycle", config_en, 0);
        tick();
        check("cfg_en_pulse", config_en, {NR{1'b1}});
        tick();
        check("cfg_en_after", config_en, 0);
        b_wait();
        axi_write(8'h28, 32'h0, 4'hF);
        axi_read(8'h28, 1'b0, r);
        check("busy_lock", r, 32'hFFFF56FF);
        check("start_pulses", en_pulses - base_p, 1);
        pulse_done();
        axi_read(8'h00, 1'b0, r);
        check("ctrl_after_done", r, 32'h0A);
        axi_read(8'h00, 1'b0, r);
        check("ctrl_cleared", r, 32'h00);
        axi_read(8'h10, 1'b0, r);
        check("runs_1", r, 32'(runs));

        // Done coinciding with CTRL read: old value returned, done stays set
        axi_read(8'h00, 1'b1, r);
        check("coll_read_old", r, 32'h00);
        axi_read(8'h00, 1'b0, r);
        check("coll_done_kept", r, 32'h0A);

        // Auto-restart
        base_p = en_pulses;
        axi_write(8'h00, 32'h81, 4'hF);
        repeat (3) tick();
        for (int n = 0; n < 3; n++) begin
            pulse_done();
            repeat (3) tick();
        end
        check("auto_pulses", en_pulses - base_p, 4);
        axi_read(8'h10, 1'b0, r);
        check("runs_auto", r, 32'(runs));
        axi_read(8'h00, 1'b0, r);
        check("ctrl_auto", r, 32'h8B);
        axi_write(8'h00, 32'h00, 4'hF);
        pulse_done();
        repeat (2) tick();
        axi_read(8'h00, 1'b0, r);
        check("ctrl_auto_off", r, 32'h0A);
        check("no_restart", en_pulses - base_p, 4);

`ifdef PIPEARCH_CTRL_IRQ_EN
        axi_write(8'h0C, 32'h1, 4'hF);
        axi_write(8'h04, 32'h1, 4'hF);
        tick();
        check("irq_idle", interrupt, 0);
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        runs++;
        check("irq_set", interrupt, 1);
        axi_write(8'h0C, 32'h1, 4'hF);
        check("irq_cleared", interrupt, 0);
`else
        check("irq_never", irq_seen, 0);
`endif

        // Reset while a write response is pending
        aw_w(8'h20, 32'h1234, 4'hF);
        check("pre_rst_bvalid", bvalid, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_cfg_en", config_en, 0);
        check("mid_rst_irq", interrupt, 0);
        @(negedge clk) reset = 1'b0;
        tick();
        runs = 0;
        axi_read(8'h20, 1'b0, r);
        check("post_rst_cfg0", r, 32'h0);
        axi_read(8'h10, 1'b0, r);
        check("post_rst_runs", r, 32'(runs));

        // Randomized config traffic against the array model
        for (int i = 0; i < NR; i++) cfg_m[i] = 64'h0;
        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 23));
            a = 8'(32'h20 + 4 * k);
            if ($urandom_range(0, 2) != 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s);
                model_wr(a, d, s);
            end else begin
                axi_read(a, 1'b0, r);
                check($sformatf("rand_rd_%h", a), r, model_rd(a));
            end
        end
        for (int i = 0; i < NR; i++)
            check($sformatf("rand_cfg%0d", i), config_data[64*i +: 64], cfg_m[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipearch_ctrl_regfile.md
Name: pipearch_ctrl_regfile

Overview:
- Parametrised AXI4-Lite control slave plus start/done sequencer for PipeArch kernels on the Xilinx shell.
- Generalises the fixed four-register control interface to NUM_REGS 64-bit config registers, with byte strobes, a busy write-lock, auto-restart and a completed-run counter.
- Sits between the shell's s_axi_control port and the kernel top.
- Emits one config-load pulse per run and tracks kernel idle/done.

Parameters:
- NUM_REGS, 8, number of 64-bit config registers (1..32).
- C_S_AXI_CONTROL_ADDR_WIDTH, 8, byte address width; must satisfy 2^W >= 0x20 + 8*NUM_REGS.
- C_S_AXI_CONTROL_DATA_WIDTH, 32, fixed at 32.

Ports:
- clk  in  1  kernel clock.
- reset  in  1  asynchronous, active-high reset.
- s_axi_control_AWVALID/AWREADY  in/out  1  write address handshake.
- s_axi_control_AWADDR  in  ADDR_WIDTH  write address.
- s_axi_control_WVALID/WREADY  in/out  1  write data handshake.
- s_axi_control_WDATA  in  32  write data.
- s_axi_control_WSTRB  in  4  write byte strobes.
- s_axi_control_BVALID/BREADY  out/in  1  write response handshake.
- s_axi_control_BRESP  out  2  write response.
- s_axi_control_ARVALID/ARREADY  in/out  1  read address handshake.
- s_axi_control_ARADDR  in  ADDR_WIDTH  read address.
- s_axi_control_RVALID/RREADY  out/in  1  read data handshake.
- s_axi_control_RDATA  out  32  read data.
- s_axi_control_RRESP  out  2  read response.
- config_data  out  64*NUM_REGS  register i occupies bits [64i+63:64i].
- config_en  out  NUM_REGS  all bits pulse together for one cycle per run start.
- ctrl_idle  in  1  kernel idle.
- ctrl_done  in  1  kernel completion, one-cycle pulse.
- interrupt  out  1  level interrupt (tied 0 without the optional feature).

Behaviour:
- Reset (async assert, sync release): all outputs 0; ap_start, ap_done, auto_restart, run_count and config registers cleared.
- Address map:
  - 0x00 CTRL: bit0 ap_start (R/W1S), bit1 ap_done (read-only, clear-on-read), bit2 ap_idle (= ctrl_idle), bit3 ap_ready (= ap_done), bit7 auto_restart (R/W).
  - 0x04 GIE, 0x08 IER, 0x0C ISR (see Optional Feature).
  - 0x10 RUNS: read-only 32-bit count of completed runs, wraps at 2^32.
  - 0x20+8i: low word of config register i; 0x24+8i: high word.
- Write channel:
  - AW and W are captured independently, each into a 1-deep holding register.
  - AWREADY is high when no AW is held and BVALID=0; WREADY likewise for W.
  - The register update occurs in the cycle both are held; BVALID rises the next cycle and holds until BREADY. BRESP is always OKAY.
  - WSTRB applies per byte.
- Read channel: ARREADY = ~RVALID. RDATA/RVALID are registered one cycle after the AR handshake and held until RREADY. RRESP is OKAY.
- Unmapped addresses: reads return 0; writes are dropped with an OKAY response.
- Busy lock: while ap_start=1, writes to config registers are dropped (OKAY response); CTRL bit7 stays writable.
- Start: writing CTRL with bit0=1 while ap_start=0 sets ap_start. config_en=all-ones for exactly one cycle, the cycle after ap_start rises. config_data is stable that cycle. A start write while ap_start=1 is ignored.
- Completion: ctrl_done sets ap_done and increments run_count.
  - auto_restart=0: ap_start clears in the same update.
  - auto_restart=1: ap_start stays 1 and config_en pulses again 1 cycle after ctrl_done.
- Collisions:
  - ctrl_done in the same cycle as a CTRL read: the read returns the old ap_done and ap_done remains set afterwards (set wins).
  - ctrl_done in the same cycle as a start write: start is ignored (ap_start was 1).
- A read of CTRL clears ap_done at read-data capture.

Optional Feature:
- Macro: PIPEARCH_CTRL_IRQ_EN.
- Defined:
  - GIE bit0 is global enable; IER bit0 enables done.
  - ISR bit0 is set on ctrl_done when IER bit0=1; writing 1 toggles it.
  - interrupt = GIE[0] & ISR[0], registered (1-cycle latency).
- Undefined: 0x04–0x0C read 0, writes are dropped, interrupt is tied 0.

Decomposition:
- Shared package pipearch_ctrl_pkg: address offsets (CTRL, GIE, IER, ISR, RUNS, CFG_BASE), CTRL bit indices, and the typedef cfg_reg_t (logic [63:0]).
- One natural sub-module: pipearch_axil_slave_if, holding the AW/W/B/AR/R handshake logic and presenting wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data to the register file.

Test Plan:
- Reset mid-transaction: assert reset with BVALID=1 → BVALID, RVALID, config_en and interrupt all 0 immediately; register 0 reads 0.
- Strobed write: write 0x20=0xAABBCCDD with WSTRB=0x5, then 0x24=0x11223344 with full strobe → config_data[63:0]=0x1122334400BB00DD.
- AW before W: AW at cycle 0, W at cycle 3 → update at cycle 3, BVALID at cycle 4; hold BREADY low 5 cycles → BVALID stays high.
- Start/done: write CTRL=0x1 → config_en=0xFF for 1 cycle. A write to 0x28 while busy is dropped. ctrl_done pulse → CTRL reads 0x0A then 0x00 (ctrl_idle=0); RUNS=1.
- Auto-restart: CTRL=0x81, three ctrl_done pulses → four config_en pulses, RUNS=3, ap_start still 1. Then write CTRL=0x00 → the next ctrl_done clears ap_start.
- IRQ (macro defined): GIE=1, IER=1, ctrl_done → interrupt=1 next cycle; write ISR=1 → interrupt=0. With the macro undefined, interrupt stays 0 and 0x08 reads 0.
